// File: rtl/mest_pro_exec_pkg.sv
// Shared types for the MEST Pro execute unit: opcode and FSM encodings,
// default widths and the NZCV flag bundle.
package mest_pro_exec_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_NOT  = 4'd8,
    OP_PASS = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/mest_pro_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, LSB first
// on op_b. Compiled only when MEST_PRO_MUL_EN is defined.
`ifdef MEST_PRO_MUL_EN
module mest_pro_mul_iter
  import mest_pro_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic                busy;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  // upper half is the accumulator, lower half the multiplier being shifted out
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     sum;

  // Next accumulator value for the step taken this cycle; on the last step
  // this is the finished product, so the parent can capture it directly.
  always_comb begin
    sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    product = {sum, acc[DATA_W-1:1]};
  end

  assign done = busy && (cnt == CNT_W'(DATA_W - 1));

  // Control: busy flag and step counter.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Datapath: latch operands with a cleared accumulator, then shift-add.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand <= op_a;
      acc   <= {{DATA_W{1'b0}}, op_b};
    end else if (busy) begin
      acc <= product;
    end
  end

endmodule
`endif

// File: rtl/mest_pro_alu_pipe.sv
// MEST Pro execute unit: width-configurable ALU with valid/ready on both
// sides and NZCV flags. Define MEST_PRO_MUL_EN to build the iterative
// multiplier; without it MUL completes in one cycle as an illegal opcode.
module mest_pro_alu_pipe
  import mest_pro_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_op_code,
  input  logic [DATA_W-1:0] i_operand1,
  input  logic [DATA_W-1:0] i_operand2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_result_hi,
  output logic              o_carry,
  output logic              o_zero_flag,
  output logic              o_neg,
  output logic              o_ovf,
  output logic              o_illegal
);

  localparam int MSB = DATA_W - 1;

  state_e            state, state_nx, accept_target;
  logic              accept, accept_single, is_mul;
  logic              op_hi_nz;
  op_e               op_dec;

  logic [DATA_W:0]   wide_c;
  logic [DATA_W-1:0] res_c;
  flags_t            fl_c;
  logic              ill_c;

  logic [DATA_W-1:0] res_p1;
  flags_t            flags_p1;
  logic              ill_p1;
  logic              vld_p1;

  // Opcodes beyond the 4-bit encoding space are always illegal.
  assign op_hi_nz = |(i_op_code >> 4);
  assign op_dec   = op_e'(i_op_code[3:0]);

  assign o_ready       = ~i_reset & ((state == ST_IDLE) | ((state == ST_HOLD) & i_ready));
  assign accept        = i_valid & o_ready;
  assign accept_single = accept & ~is_mul;

`ifdef MEST_PRO_MUL_EN
  logic [DATA_W-1:0]   res_hi_p1;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic [DATA_W-1:0]   mul_hi;
  flags_t              mul_fl;

  assign is_mul        = ~op_hi_nz & (op_dec == OP_MUL);
  assign accept_target = is_mul ? ST_MUL : ST_HOLD;

  mest_pro_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .i_reset (i_reset),
    .start   (accept & is_mul),
    .op_a    (i_operand1),
    .op_b    (i_operand2),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_hi = mul_prod[2*DATA_W-1:DATA_W];

  // Flags for a finished product: zero covers the full double-width result.
  always_comb begin
    mul_fl   = '0;
    mul_fl.c = |mul_hi;
    mul_fl.z = (mul_prod == '0);
    mul_fl.n = mul_hi[MSB];
  end

  assign o_result_hi = res_hi_p1;
`else
  assign is_mul        = 1'b0;
  assign accept_target = ST_HOLD;
  assign o_result_hi   = '0;
`endif

  // Single-cycle operations on the offered operands; unsigned, with one
  // extra bit so carry/borrow falls out of the add/subtract.
  always_comb begin
    wide_c = '0;
    res_c  = '0;
    fl_c   = '0;
    ill_c  = 1'b0;
    if (op_hi_nz) begin
      ill_c = 1'b1;
    end else begin
      case (op_dec)
        OP_ADD: begin
          wide_c = {1'b0, i_operand1} + {1'b0, i_operand2};
          res_c  = wide_c[MSB:0];
          fl_c.c = wide_c[DATA_W];
          fl_c.v = (i_operand1[MSB] == i_operand2[MSB]) & (res_c[MSB] != i_operand1[MSB]);
        end
        OP_SUB: begin
          wide_c = {1'b0, i_operand1} - {1'b0, i_operand2};
          res_c  = wide_c[MSB:0];
          fl_c.c = wide_c[DATA_W];
          fl_c.v = (i_operand1[MSB] != i_operand2[MSB]) & (res_c[MSB] != i_operand1[MSB]);
        end
        OP_AND:  res_c = i_operand1 & i_operand2;
        OP_OR:   res_c = i_operand1 | i_operand2;
        OP_XOR:  res_c = i_operand1 ^ i_operand2;
        OP_SHR: begin
          res_c  = {1'b0, i_operand1[MSB:1]};
          fl_c.c = i_operand1[0];
        end
        OP_SHL: begin
          res_c  = {i_operand1[MSB-1:0], 1'b0};
          fl_c.c = i_operand1[MSB];
        end
        OP_NOT:  res_c = ~i_operand1;
        OP_PASS: res_c = i_operand1;
        default: ill_c = 1'b1;
      endcase
    end
    if (!ill_c) begin
      fl_c.z = (res_c == '0);
      fl_c.n = res_c[MSB];
    end
  end

  // Next-state logic: HOLD with a taken result behaves like IDLE for a new op.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = accept_target;
`ifdef MEST_PRO_MUL_EN
      ST_MUL:  if (mul_done) state_nx = ST_HOLD;
`endif
      ST_HOLD: if (i_ready) state_nx = accept ? accept_target : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // ---- stage p1: result registers, loaded at accept or multiplier finish ----
  // Result and flag registers; held untouched while the consumer stalls.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      res_p1    <= '0;
`ifdef MEST_PRO_MUL_EN
      res_hi_p1 <= '0;
`endif
      flags_p1  <= '0;
      ill_p1    <= 1'b0;
    end else if (accept_single) begin
      res_p1    <= res_c;
`ifdef MEST_PRO_MUL_EN
      res_hi_p1 <= '0;
`endif
      flags_p1  <= fl_c;
      ill_p1    <= ill_c;
    end
`ifdef MEST_PRO_MUL_EN
    else if (mul_done) begin
      res_p1    <= mul_prod[DATA_W-1:0];
      res_hi_p1 <= mul_hi;
      flags_p1  <= mul_fl;
      ill_p1    <= 1'b0;
    end
`endif
  end

  assign vld_p1      = (state == ST_HOLD);
  assign o_valid     = vld_p1;
  assign o_result    = res_p1;
  assign o_carry     = flags_p1.c;
  assign o_zero_flag = flags_p1.z;
  assign o_neg       = flags_p1.n;
  assign o_ovf       = flags_p1.v;
  assign o_illegal   = ill_p1;

endmodule

// File: tb/tb_mest_pro_alu_pipe.sv
// Bench for mest_pro_alu_pipe (DATA_W=8). A reference model computes each
// accepted operation's result from arithmetic on integers; a monitor checks
// every valid output cycle against it, plus literal expectations for the
// directed vectors. MUL behaviour follows MEST_PRO_MUL_EN.
module tb_mest_pro_alu_pipe;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    i_op_code;
  logic [DW-1:0] i_operand1, i_operand2;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_result, o_result_hi;
  logic          o_carry, o_zero_flag, o_neg, o_ovf, o_illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] hi;
    logic c, z, n, v, ill;
    bit   mul;
    int   due;
  } exp_t;

  exp_t q[$];
  bit   front_seen = 1'b0;

  mest_pro_alu_pipe #(.DATA_W(DW), .OP_W(4)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op_code   (i_op_code),
    .i_operand1  (i_operand1),
    .i_operand2  (i_operand2),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_result_hi (o_result_hi),
    .o_carry     (o_carry),
    .o_zero_flag (o_zero_flag),
    .o_neg       (o_neg),
    .o_ovf       (o_ovf),
    .o_illegal   (o_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each opcode.
  function automatic exp_t model(input int op, input int a_i, input int b_i);
    exp_t   e;
    longint a, b, mask, half, sa, sb, ss, p, r, hi;
    bit     ill;
    a = a_i; b = b_i;
    mask = (longint'(1) << DW) - 1;
    half = longint'(1) << (DW - 1);
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    r = 0; hi = 0; p = 0; ill = 0;
    e.c = 0; e.z = 0; e.n = 0; e.v = 0; e.mul = 0;
    case (op)
      0: begin r = (a + b) & mask; e.c = (a + b) > mask; ss = sa + sb; e.v = (ss >= half) || (ss < -half); end
      1: begin r = (a - b) & mask; e.c = (a < b); ss = sa - sb; e.v = (ss >= half) || (ss < -half); end
`ifdef MEST_PRO_MUL_EN
      2: begin p = a * b; r = p & mask; hi = p >> DW; e.mul = 1; end
`endif
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin r = a >> 1; e.c = a[0]; end
      7: begin r = (a << 1) & mask; e.c = (a >> (DW - 1)) & 1; end
      8: r = (~a) & mask;
      9: r = a;
      default: ill = 1;
    endcase
    if (ill) begin
      r = 0; hi = 0; e.c = 0; e.v = 0;
    end else if (e.mul) begin
      e.c = (hi != 0);
      e.z = (p == 0);
      e.n = (hi >> (DW - 1)) & 1;
    end else begin
      e.z = (r == 0);
      e.n = (r >> (DW - 1)) & 1;
    end
    e.r = r[DW-1:0];
    e.hi = hi[DW-1:0];
    e.ill = ill;
    e.due = 0;
    return e;
  endfunction

  function automatic logic [2*DW+4:0] pack_exp(input exp_t e);
    return {e.r, e.hi, e.c, e.z, e.n, e.v, e.ill};
  endfunction

  // Monitor: compares every meaningful output cycle against the model.
  always @(negedge clk) begin
    exp_t e;
    if (i_reset) begin
      chk("ready_in_reset", o_ready, 0);
      q.delete();
      front_seen = 1'b0;
    end else begin
      if (q.size() == 0) begin
        chk("idle_valid", o_valid, 0);
      end else begin
        if (!front_seen) begin
          if (o_valid) begin
            chk("latency", cyc, q[0].due);
            front_seen = 1'b1;
          end else if (q[0].mul) begin
            chk("ready_during_mul", o_ready, 0);
          end
        end
        if (!o_valid && !front_seen && cyc >= q[0].due) begin
          chk("result_late", o_valid, 1);
          void'(q.pop_front());
        end else if (o_valid) begin
          chk("result", {o_result, o_result_hi, o_carry, o_zero_flag, o_neg, o_ovf, o_illegal},
              pack_exp(q[0]));
          if (i_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (i_valid && o_ready) begin
        e = model(int'(i_op_code), int'(i_operand1), int'(i_operand2));
        e.due = cyc + 1 + (e.mul ? DW : 0);
        q.push_back(e);
      end
    end
  end

  // Offer an op and wait for its accept edge; returns just after that edge.
  task automatic send(input int op, input int a, input int b, input bit keep);
    bit ok;
    ok = 0;
    i_valid    = 1'b1;
    i_op_code  = op[3:0];
    i_operand1 = a[DW-1:0];
    i_operand2 = b[DW-1:0];
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (o_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!keep) i_valid = 1'b0;
  endtask

  // Wait for o_valid; n is the 1-based cycle count after the accept edge.
  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int s_op[9] = '{0, 7, 6, 8, 3, 4, 9, 10, 1};
  int s_a [9] = '{8'h7F, 8'h81, 8'h81, 8'h0F, 8'hCC, 8'hC0, 8'h00, 8'h01, 8'h05};
  int s_b [9] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h03, 8'h00, 8'h01, 8'h05};

  initial begin
    int n, c0;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_op_code = '0; i_operand1 = '0; i_operand2 = '0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", o_ready, 1);
    chk("reset_valid", o_valid, 0);
    chk("reset_outputs", {o_result, o_result_hi, o_carry, o_zero_flag, o_neg, o_ovf, o_illegal}, 0);
    @(posedge clk); #1;

    // ADD 0xFF + 0x01
    send(0, 8'hFF, 8'h01, 0);
    wait_valid(n);
    chk("add_latency", n, 1);
    chk("add_res", o_result, 8'h00);
    chk("add_flags", {o_carry, o_zero_flag, o_neg, o_ovf}, 4'b1100);
    idle(1);

    // SUB 0x80 - 0x01 and 0x01 - 0x02
    send(1, 8'h80, 8'h01, 0);
    wait_valid(n);
    chk("sub1_res", o_result, 8'h7F);
    chk("sub1_flags", {o_carry, o_zero_flag, o_neg, o_ovf}, 4'b0001);
    idle(1);
    send(1, 8'h01, 8'h02, 0);
    wait_valid(n);
    chk("sub2_res", o_result, 8'hFF);
    chk("sub2_flags", {o_carry, o_zero_flag, o_neg, o_ovf}, 4'b1010);
    idle(1);

    // Back-pressure: ADD 3+4 held, then XOR taken in the same cycle as the result
    i_ready = 1'b0;
    send(0, 3, 4, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_res", o_result, 8'h07);
      chk("bp_ready", o_ready, 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b1; i_op_code = 4'd5; i_operand1 = 8'hF0; i_operand2 = 8'h0F;
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("xor_valid", o_valid, 1);
    chk("xor_res", o_result, 8'hFF);
    chk("xor_flags", {o_carry, o_zero_flag, o_neg, o_ovf}, 4'b0010);
    idle(2);

    // Illegal opcode 0xF
    send(15, 8'h12, 8'h34, 0);
    wait_valid(n);
    chk("ill_flag", o_illegal, 1);
    chk("ill_res", {o_result, o_result_hi, o_carry, o_zero_flag, o_neg, o_ovf}, 0);
    idle(1);

`ifdef MEST_PRO_MUL_EN
    send(2, 8'h10, 8'h20, 0);
    wait_valid(n);
    chk("mul_latency", n, 9);
    chk("mul_lo", o_result, 8'h00);
    chk("mul_hi", o_result_hi, 8'h02);
    chk("mul_flags", {o_carry, o_zero_flag, o_neg, o_ovf, o_illegal}, 5'b10000);
    idle(1);
    send(2, 8'hFF, 8'hFF, 0);
    wait_valid(n);
    chk("mul_ff_hi", o_result_hi, 8'hFE);
    idle(1);
    send(2, 3, 5, 0);
    idle(2);
`else
    send(2, 3, 3, 0);
    wait_valid(n);
    chk("mul_off_latency", n, 1);
    chk("mul_off_illegal", o_illegal, 1);
    chk("mul_off_res", {o_result, o_result_hi}, 0);
    idle(1);
    i_ready = 1'b0;
    send(0, 8'h22, 8'h11, 0);
    idle(2);
`endif

    // Reset in the middle of work
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_outputs", {o_result, o_result_hi, o_carry, o_zero_flag, o_neg, o_ovf, o_illegal}, 0);
    @(posedge clk); #1;
    send(9, 8'h5A, 8'h00, 0);
    wait_valid(n);
    chk("pass_res", o_result, 8'h5A);
    idle(2);

    // Back-to-back stream at one op per cycle
    c0 = cyc;
    for (int i = 0; i < 9; i++) send(s_op[i], s_a[i], s_b[i], 1);
    i_valid = 1'b0;
    chk("throughput", cyc - c0, 9);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
